// File: rtl/mic_i2s_capture.sv
// I2S master for a 24-bit MEMS microphone: generates SCK/WS, captures the
// left slot of each frame and buffers samples in a FIFO with level flags/irq.
module mic_i2s_capture #(
    parameter int CLK_DIV   = 8,
    parameter int FIFO_AW   = 4,
    parameter int IRQ_LEVEL = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        read_audio,
    output logic [23:0] audio,
    output logic        full,
    output logic        empty,
    output logic        irq,
    output logic        mic_sck,
    output logic        mic_ws,
    input  logic        mic_sd
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int LW    = FIFO_AW + 1;

    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_IRQ  = LW'(IRQ_LEVEL);
    localparam logic [LW-1:0] LVL_PRE  = LW'(IRQ_LEVEL - 1);

    logic [DW-1:0]      div_q, div_d;
    logic               sck_q, sck_d;
    logic               ws_q, ws_d;
    logic [5:0]         bit_q, bit_d;
    logic [22:0]        shift_q, shift_d;
    logic               sd_q;

    logic [FIFO_AW-1:0] wr_q, wr_d;
    logic [FIFO_AW-1:0] rd_q, rd_d;
    logic [LW-1:0]      level_q, level_d;
    logic [23:0]        audio_q, audio_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               irq_q, irq_d;
    logic [23:0]        mem_q [DEPTH];

    logic tick, rise, fall;
    logic shift_en, push, pop, push_ok;
    logic [23:0] word;

    assign tick     = enable && (div_q == DIV_MAX);
    assign rise     = tick && !sck_q;
    assign fall     = tick && sck_q;
    assign shift_en = rise && (bit_q >= 6'd1) && (bit_q <= 6'd24);
    assign push     = rise && (bit_q == 6'd24);
    assign word     = {shift_q, sd_q};

    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign pop     = read_audio && !empty_q;
    assign push_ok = push && (!full_q || pop);

    always_comb begin
        div_d   = div_q;
        sck_d   = sck_q;
        ws_d    = ws_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (!enable) begin
            div_d   = '0;
            sck_d   = 1'b0;
            ws_d    = 1'b0;
            bit_d   = '0;
            shift_d = '0;
        end else begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) begin
                sck_d = ~sck_q;
            end
            if (fall) begin
                bit_d = bit_q + 6'd1;
                ws_d  = bit_d[5];
            end
            if (shift_en) begin
                shift_d = {shift_q[21:0], sd_q};
            end
        end
    end

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        audio_d = audio_q;
        level_d = level_q + LW'(push_ok) - LW'(pop);
        if (push_ok) begin
            wr_d = wr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + FIFO_AW'(1);
        end
        if (read_audio) begin
            audio_d = pop ? mem_q[rd_q] : '0;
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_FULL);
        irq_d   = (level_q == LVL_PRE) && (level_d == LVL_IRQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            sck_q   <= 1'b0;
            ws_q    <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            sd_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            sck_q   <= sck_d;
            ws_q    <= ws_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sd_q    <= mic_sd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            audio_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            audio_q <= audio_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            irq_q   <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_q] <= word;
        end
    end

    assign audio   = audio_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign irq     = irq_q;
    assign mic_sck = sck_q;
    assign mic_ws  = ws_q;

endmodule

// File: tb/tb_mic_i2s_capture.sv
// Directed bench for mic_i2s_capture: an I2S mic model driven from mic_sck,
// a pop-expectation table and hand sequences for the multi-cycle corners.
module tb_mic_i2s_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        read_audio = 1'b0;
    logic        mic_sd = 1'b0;
    logic [23:0] audio;
    logic        full, empty, irq, mic_sck, mic_ws;

    int total = 0;
    int bad = 0;
    int irq_cnt = 0;
    int tbcnt = 0;
    logic [23:0] left_w = '0;
    logic [23:0] right_w = '0;

    typedef struct {
        logic [23:0] exp_audio;
        logic        exp_full;
        logic        exp_empty;
    } pop_vec_t;

    pop_vec_t tbl [17];

    mic_i2s_capture #(
        .CLK_DIV(2),
        .FIFO_AW(4),
        .IRQ_LEVEL(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .read_audio(read_audio),
        .audio(audio),
        .full(full),
        .empty(empty),
        .irq(irq),
        .mic_sck(mic_sck),
        .mic_ws(mic_ws),
        .mic_sd(mic_sd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irq) irq_cnt++;
    end

    // Mic drives the next bit on each SCK fall; unused slots carry ones.
    function automatic logic sd_bit(input int c);
        if (c >= 1 && c <= 24) return left_w[24 - c];
        if (c >= 33 && c <= 56) return right_w[56 - c];
        return 1'b1;
    endfunction

    always @(negedge mic_sck or negedge enable or posedge rst) begin
        if (rst || !enable) begin
            tbcnt = 0;
            mic_sd = 1'b0;
        end else begin
            tbcnt = (tbcnt == 63) ? 0 : tbcnt + 1;
            mic_sd = sd_bit(tbcnt);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bit(input int target);
        int n = 0;
        while (tbcnt == target && n < 600) begin
            tick();
            n++;
        end
        while (tbcnt != target && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) begin
            total++;
            bad++;
            $display("FAIL wait_bit_%0d: got timeout want bit", target);
        end
    endtask

    task automatic stop();
        enable = 1'b0;
        tick();
    endtask

    task automatic capture(input logic [23:0] l);
        left_w = l;
        enable = 1'b1;
        wait_bit(25);
    endtask

    task automatic pop(input string nm, input logic [23:0] exp);
        read_audio = 1'b1;
        tick();
        read_audio = 1'b0;
        chk(nm, audio, exp);
    endtask

    // Pop lands on the same edge as the bit-24 rise that pushes the word.
    task automatic capture_with_pop(input logic [23:0] l,
                                    input logic [23:0] exp);
        left_w = l;
        enable = 1'b1;
        wait_bit(24);
        tick();
        read_audio = 1'b1;
        tick();
        read_audio = 1'b0;
        chk("cwp_audio", audio, exp);
        chk("cwp_sck", mic_sck, 1'b1);
        wait_bit(25);
    endtask

    initial begin
        int n, t, hi;

        for (int k = 0; k < 16; k++) begin
            tbl[k].exp_audio = 24'(k + 1);
            tbl[k].exp_full  = 1'b0;
            tbl[k].exp_empty = (k == 15);
        end
        tbl[16].exp_audio = 24'h0;
        tbl[16].exp_full  = 1'b0;
        tbl[16].exp_empty = 1'b1;

        // Reset state and idle outputs
        repeat (3) tick();
        chk("rst_sck", mic_sck, 0);
        chk("rst_ws", mic_ws, 0);
        chk("rst_audio", audio, 0);
        chk("rst_irq", irq, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mic_sck || mic_ws) hi++;
        end
        chk("idle_pins", hi, 0);

        // SCK/WS timing
        enable = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!mic_sck && n < 20);
        chk("first_rise", n, 2);
        t = n;
        n = 0;
        do begin tick(); n++; end while (mic_sck && n < 20);
        do begin tick(); n++; end while (!mic_sck && n < 20);
        chk("sck_period", n, 4);
        t += n;
        do begin tick(); t++; end while (!mic_ws && t < 400);
        chk("ws_rise", t, 128);
        n = 0;
        do begin tick(); n++; end while (mic_ws && n < 400);
        chk("ws_half", n, 128);
        stop();
        chk("dis_sck", mic_sck, 0);
        chk("dis_ws", mic_ws, 0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Single sample with latency check; right slot ignored
        left_w = 24'hA5C3F1;
        right_w = 24'hFFFFFF;
        enable = 1'b1;
        wait_bit(24);
        chk("pre_push_a", empty, 1);
        tick();
        chk("pre_push_b", empty, 1);
        tick();
        chk("push_latency", empty, 0);
        wait_bit(25);
        stop();
        right_w = 24'h0;
        pop("pop_a5", 24'hA5C3F1);
        chk("pop_a5_empty", empty, 1);

        // Fill to full, overflow drop, drain in order
        for (int i = 1; i <= 17; i++) begin
            capture(24'(i));
            chk("fill_full", full, (i >= 16));
            if (i == 7) chk("irq_before8", irq_cnt, 0);
            if (i == 8) chk("irq_at8", irq_cnt, 1);
        end
        stop();
        chk("irq_once", irq_cnt, 1);
        for (int k = 0; k < 17; k++) begin
            read_audio = 1'b1;
            tick();
            read_audio = 1'b0;
            chk("tbl_audio", audio, tbl[k].exp_audio);
            chk("tbl_full", full, tbl[k].exp_full);
            chk("tbl_empty", empty, tbl[k].exp_empty);
        end
        chk("irq_no_drain", irq_cnt, 1);

        // irq re-arm
        for (int i = 1; i <= 8; i++) capture(24'h300000 + 24'(i));
        stop();
        chk("irq_second", irq_cnt, 2);
        pop("pop_to7", 24'h300001);
        capture(24'h300009);
        chk("irq_third", irq_cnt, 3);
        capture(24'h30000A);
        chk("irq_no_repeat", irq_cnt, 3);
        for (int i = 11; i <= 17; i++) capture(24'h300000 + 24'(i));
        stop();
        chk("refull", full, 1);

        // Coincident push/pop at full and at empty
        capture_with_pop(24'h300012, 24'h300002);
        stop();
        chk("cwp_full_flag", full, 1);
        for (int k = 0; k < 16; k++) begin
            pop("cwp_drain", 24'h300003 + 24'(k));
        end
        chk("cwp_drain_empty", empty, 1);
        capture_with_pop(24'hABCDEF, 24'h0);
        stop();
        chk("cwp_empty_flag", empty, 0);
        pop("cwp_empty_data", 24'hABCDEF);
        chk("cwp_empty_after", empty, 1);
        pop("read_empty", 24'h0);

        // Enable dropped mid-word
        left_w = 24'hDEAD00;
        enable = 1'b1;
        wait_bit(12);
        enable = 1'b0;
        repeat (3) tick();
        chk("drop_sck", mic_sck, 0);
        chk("drop_ws", mic_ws, 0);
        chk("drop_empty", empty, 1);
        capture(24'h123456);
        stop();
        pop("after_drop", 24'h123456);

        // Reset mid-frame
        capture(24'h111111);
        capture(24'h222222);
        pop("pre_rst_pop", 24'h111111);
        wait_bit(40);
        chk("pre_rst_ws", mic_ws, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_sck", mic_sck, 0);
        chk("mid_rst_ws", mic_ws, 0);
        chk("mid_rst_audio", audio, 0);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        capture(24'h777777);
        stop();
        pop("post_rst", 24'h777777);
        chk("post_rst_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
